// File: rtl/acl_spi_responder.sv
`timescale 1ns/1ps
// SPI mode-0 register-map responder for the accelerometer front end.
// SPI pins are oversampled on clk; reads/writes use an auto-incrementing pointer.
module acl_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int REG_DEPTH   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_i,
  input  logic        ncs_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [15:0] temp_data_i,
  output logic        wr_valid_o,
  output logic [7:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o,
  output logic        frame_err_o
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, READ, WRITE, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sq, ncs_sq, mosi_sq;
  logic        sclk_pq, ncs_pq;
  logic [2:0]  cnt_q;
  logic [6:0]  rx_q;
  logic [7:0]  tx_q;
  logic [7:0]  ptr_q;
  logic        wr_cmd_q;
  logic [15:0] temp_q;
  logic        wr_valid_q, ferr_q;
  logic [7:0]  wr_addr_q, wr_data_q;
  logic [7:0]  regs_q [REG_DEPTH];

  logic sclk_s, ncs_s, mosi_s;
  logic sclk_rise, sclk_fall, ncs_fall, ncs_rise;
  logic byte_done;
  logic [7:0] byte_w;

  assign sclk_s = sclk_sq[SYNC_STAGES-1];
  assign ncs_s  = ncs_sq[SYNC_STAGES-1];
  assign mosi_s = mosi_sq[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_pq;
  assign sclk_fall = ~sclk_s & sclk_pq;
  // ncs chain resets low so a select held across rst never looks like a fall
  assign ncs_fall  = ncs_pq & ~ncs_s;
  assign ncs_rise  = ~ncs_pq & ncs_s;

  assign byte_w    = {rx_q, mosi_s};
  assign byte_done = sclk_rise && (cnt_q == 3'd7);

  function automatic logic [7:0] rd_byte(input logic [7:0] a);
    logic [7:0] r;
    if (int'(a) >= REG_DEPTH) r = 8'h00;
    else if (a == 8'h14)      r = temp_q[7:0];
    else if (a == 8'h15)      r = temp_q[15:8];
    else                      r = regs_q[a[AW-1:0]];
    return r;
  endfunction

  function automatic logic wr_ok(input logic [7:0] a);
    return (int'(a) < REG_DEPTH) && (a > 8'h03) &&
           (a != 8'h14) && (a != 8'h15);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sq <= '0;
      ncs_sq  <= '0;
      mosi_sq <= '0;
      sclk_pq <= 1'b0;
      ncs_pq  <= 1'b0;
    end else begin
      sclk_sq <= SYNC_STAGES'({sclk_sq, sclk_i});
      ncs_sq  <= SYNC_STAGES'({ncs_sq, ncs_i});
      mosi_sq <= SYNC_STAGES'({mosi_sq, mosi_i});
      sclk_pq <= sclk_s;
      ncs_pq  <= ncs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (ncs_fall) state_d = CMD;
      CMD: begin
        if (byte_done)
          state_d = (byte_w == 8'h0B || byte_w == 8'h0A) ? ADDR : IGNORE;
      end
      ADDR:   if (byte_done) state_d = wr_cmd_q ? WRITE : READ;
      default: ;
    endcase
    if (ncs_rise) state_d = IDLE;
  end

  assign busy_o      = (state_q != IDLE);
  assign miso_oe_o   = busy_o;
  assign miso_o      = (state_q == READ) & tx_q[7];
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      wr_cmd_q   <= 1'b0;
      temp_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ferr_q     <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
      regs_q[0] <= 8'hAD;
      regs_q[1] <= 8'h1D;
      regs_q[2] <= 8'hF2;
      regs_q[3] <= 8'h01;
    end else begin
      wr_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      if (ncs_rise) begin
        ferr_q <= (state_q != IDLE) && (cnt_q != 3'd0);
        cnt_q  <= '0;
      end else if (ncs_fall && state_q == IDLE) begin
        cnt_q  <= '0;
        temp_q <= temp_data_i;
      end else if (state_q != IDLE) begin
        if (sclk_rise) begin
          cnt_q <= cnt_q + 3'd1;
          rx_q  <= byte_w[6:0];
          if (cnt_q == 3'd7) begin
            unique case (state_q)
              CMD:  wr_cmd_q <= (byte_w == 8'h0A);
              ADDR: begin
                ptr_q <= byte_w;
                tx_q  <= rd_byte(byte_w);
              end
              READ: begin
                ptr_q <= ptr_q + 8'd1;
                tx_q  <= rd_byte(ptr_q + 8'd1);
              end
              WRITE: begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= ptr_q;
                wr_data_q  <= byte_w;
                if (wr_ok(ptr_q)) regs_q[ptr_q[AW-1:0]] <= byte_w;
                ptr_q <= ptr_q + 8'd1;
              end
              default: ;
            endcase
          end
        end else if (sclk_fall && state_q == READ && cnt_q != 3'd0) begin
          // the fall right after a byte boundary keeps the freshly loaded MSB
          tx_q <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end

endmodule
